// File: rtl/if_id_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_queue_pkg
//  Description : Shared widths, depth defaults and bubble value for the
//                fetch/decode instruction queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_id_queue_pkg;

    localparam int          c_ADDR_LEN        = 32;
    localparam int          c_INSTRUCTION_LEN = 32;
    localparam int          c_IFQ_DEPTH       = 4;
    localparam int          c_IFQ_PTR_LEN     = 2;
    localparam logic [31:0] c_NOP             = 32'b0;

    // Pointer width for a given depth; falls back to the shared default when it applies.
    function automatic int ifq_ptr_len(input int depth);
        return (depth == c_IFQ_DEPTH) ? c_IFQ_PTR_LEN : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_queue_mem.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_queue_mem
//  Description : DEPTH x WIDTH register array, synchronous write port and
//                combinational read port, cleared on reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_queue
//  Description : Valid/ready decoupled instruction queue between fetch and
//                decode, flushed on a taken branch. Optional zero-latency
//                empty-queue bypass under macro IF_ID_QUEUE_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH    = c_IFQ_DEPTH,
    parameter int WORD_LEN = c_ADDR_LEN,
    parameter int INST_LEN = c_INSTRUCTION_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [WORD_LEN-1:0]    in_PC,
    input  logic [INST_LEN-1:0]    in_Instruction,
    output logic                   in_ready,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [WORD_LEN-1:0]    PC,
    output logic [INST_LEN-1:0]    Instruction,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = ifq_ptr_len(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = WORD_LEN + INST_LEN;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_rd_data;
    logic [ENT_W-1:0] w_wr_data;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_wr_data = {in_PC, in_Instruction};

    // in_ready looks only at occupancy, so a full queue refuses even when popping.
    assign in_ready  = ~w_full;
    assign count     = r_count;
    assign w_pop     = ~w_empty & out_ready & ~flush;

`ifdef IF_ID_QUEUE_BYPASS_EN
    logic w_bypass;

    // An empty queue forwards the fetch pair directly; if decode takes it, it is never stored.
    assign w_bypass  = w_empty & in_valid & ~flush;
    assign w_push    = in_valid & ~w_full & ~flush & ~(w_bypass & out_ready);
    assign out_valid = ~w_empty | w_bypass;

    always_comb begin
        PC          = WORD_LEN'(c_NOP);
        Instruction = INST_LEN'(c_NOP);
        if (w_bypass) begin
            PC          = in_PC;
            Instruction = in_Instruction;
        end else if (!w_empty) begin
            PC          = w_rd_data[ENT_W-1:INST_LEN];
            Instruction = w_rd_data[INST_LEN-1:0];
        end
    end
`else
    assign w_push    = in_valid & ~w_full & ~flush;
    assign out_valid = ~w_empty;

    always_comb begin
        PC          = WORD_LEN'(c_NOP);
        Instruction = INST_LEN'(c_NOP);
        if (!w_empty) begin
            PC          = w_rd_data[ENT_W-1:INST_LEN];
            Instruction = w_rd_data[INST_LEN-1:0];
        end
    end
`endif

    // Reset and flush both rewind the queue; only reset also clears the storage.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (w_wr_data),
        .raddr (r_rd_ptr),
        .rdata (w_rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_queue
//  Description : Directed and random stimulus for if_id_queue against a
//                queue-based reference model of occupancy and ordering.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

    localparam int c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_PC = '0;
    logic [31:0] in_Instruction = '0;
    logic        in_ready;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    logic [63:0] model_q [$];

    always #5 clk = ~clk;

    if_id_queue #(
        .DEPTH    (c_DEPTH),
        .WORD_LEN (32),
        .INST_LEN (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_PC          (in_PC),
        .in_Instruction (in_Instruction),
        .in_ready       (in_ready),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .PC             (PC),
        .Instruction    (Instruction),
        .count          (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge, compare outputs, then advance the model.
    task automatic step(input logic s_rst, input logic s_flush, input logic s_valid,
                        input logic [31:0] s_pc, input logic [31:0] s_inst,
                        input logic s_ready, input bit do_check);
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        bit          popped;
        bit          pushed;
        @(negedge clk);
        rst            = s_rst;
        flush          = s_flush;
        in_valid       = s_valid;
        in_PC          = s_pc;
        in_Instruction = s_inst;
        out_ready      = s_ready;
        #1;
        e_valid = (model_q.size() > 0);
        e_pc    = e_valid ? model_q[0][63:32] : 32'h0;
        e_inst  = e_valid ? model_q[0][31:0]  : 32'h0;
`ifdef IF_ID_QUEUE_BYPASS_EN
        if (model_q.size() == 0 && s_valid && !s_flush) begin
            e_valid = 1'b1;
            e_pc    = s_pc;
            e_inst  = s_inst;
        end
`endif
        if (do_check) begin
            check("out_valid",   32'(out_valid), 32'(e_valid));
            check("PC",          PC,             e_pc);
            check("Instruction", Instruction,    e_inst);
            check("count",       32'(count),     32'(model_q.size()));
            check("in_ready",    32'(in_ready),  32'(model_q.size() < c_DEPTH));
        end
        if (s_rst || s_flush) begin
            model_q.delete();
        end else begin
            popped = (model_q.size() > 0) && s_ready;
            pushed = s_valid && (model_q.size() < c_DEPTH);
`ifdef IF_ID_QUEUE_BYPASS_EN
            if (model_q.size() == 0 && s_ready) pushed = 1'b0;
`endif
            if (popped) void'(model_q.pop_front());
            if (pushed) model_q.push_back({s_pc, s_inst});
        end
    endtask

    initial begin
        // Reset held for two cycles, then idle.
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 1);

        // Streaming with decode always ready.
        for (int k = 1; k <= 3; k++) step(0, 0, 1, 32'(4 * k), $urandom, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);

        // Fill while stalled, fifth word refused, then drain in order.
        for (int k = 1; k <= 5; k++) step(0, 0, 1, 32'(4 * k), $urandom, 0, 1);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 1, 1);

        // Full queue with a simultaneous pop: pop only.
        for (int k = 1; k <= 4; k++) step(0, 0, 1, 32'(4 * k), $urandom, 0, 1);
        step(0, 0, 1, 32'h44, $urandom, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 1, 1);

        // Flush with push and pop in the same cycle, then a fresh push.
        step(0, 0, 1, 32'h4, $urandom, 0, 1);
        step(0, 0, 1, 32'h8, $urandom, 0, 1);
        step(0, 1, 1, 32'hC, $urandom, 1, 1);
        step(0, 0, 1, 32'h100, $urandom, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);

        // Wrap-around with alternating decode stalls.
        for (int k = 1; k <= 10; k++) step(0, 0, 1, 32'(4 * k), $urandom, (k % 2) == 0, 1);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 0, 1, 1);

        // Empty-queue push with decode ready (same-cycle forwarding when bypass is built in).
        step(0, 0, 1, 32'h200, $urandom, 1, 1);
        step(0, 0, 1, 32'h204, $urandom, 0, 1);
        step(0, 0, 0, 0, 0, 1, 1);

        // Random traffic including rare flushes and a mid-run reset.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 9) < 7), $urandom, $urandom,
                 ($urandom_range(0, 9) < 6), 1);
        end
        step(0, 0, 0, 0, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
